// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter for an asynchronous input.
// Counts SigIn rising edges over GATE_CYCLES clock cycles, then latches the
// count into Result with a one-cycle Valid pulse; LEDR mirrors Ovf/Result.
// Optional build macro FREQ_METER_SAT_EN: saturating edge counter with a
// sticky overflow flag reported on Ovf. Without it the counter wraps and Ovf=0.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned W           = 24
) (
  input  logic         CLOCK_50,
  input  logic         Reset,
  input  logic         SigIn,
  input  logic         Enable,
  output logic [W-1:0] Result,
  output logic         Valid,
  output logic         Ovf,
  output logic [9:0]   LEDR
);

  localparam int unsigned   GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          dly_q;
  logic          edge_det;
  logic [GW-1:0] gate_q;
  logic [W-1:0]  edge_cnt_q;
  logic [W-1:0]  edge_cnt_d;
  logic [W-1:0]  result_q;
  logic          valid_q;
  logic [8:0]    res_led;

  // Two-flop synchronizer followed by a delay flop for rising-edge detection
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= SigIn;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~dly_q;

`ifdef FREQ_METER_SAT_EN
  logic ovf_sticky_q;
  logic ovf_sticky_d;
  logic ovf_q;

  // Saturating edge-count increment; any increment attempted at the maximum
  // sets the per-window sticky overflow
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    if (edge_det) begin
      if (&edge_cnt_q) begin
        ovf_sticky_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + W'(1);
      end
    end
  end

  assign Ovf = ovf_q;
`else
  // Wrapping edge-count increment
  always_comb begin
    edge_cnt_d = edge_cnt_q + W'(edge_det);
  end

  assign Ovf = 1'b0;
`endif

  // Measurement FSM: gate/edge counters and registered Result/Valid/Ovf
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      gate_q       <= '0;
      edge_cnt_q   <= '0;
      result_q     <= '0;
      valid_q      <= 1'b0;
`ifdef FREQ_METER_SAT_EN
      ovf_sticky_q <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          gate_q       <= '0;
          edge_cnt_q   <= '0;
`ifdef FREQ_METER_SAT_EN
          ovf_sticky_q <= 1'b0;
`endif
          if (Enable) begin
            state_q <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (!Enable) begin
            state_q      <= ST_IDLE;
            gate_q       <= '0;
            edge_cnt_q   <= '0;
`ifdef FREQ_METER_SAT_EN
            ovf_sticky_q <= 1'b0;
`endif
          end else if (gate_q == GATE_LAST) begin
            // The edge detected in the final gate cycle is folded into Result
            result_q     <= edge_cnt_d;
            valid_q      <= 1'b1;
            gate_q       <= '0;
            edge_cnt_q   <= '0;
`ifdef FREQ_METER_SAT_EN
            ovf_q        <= ovf_sticky_d;
            ovf_sticky_q <= 1'b0;
`endif
            state_q      <= ST_DONE;
          end else begin
            gate_q       <= gate_q + GW'(1);
            edge_cnt_q   <= edge_cnt_d;
`ifdef FREQ_METER_SAT_EN
            ovf_sticky_q <= ovf_sticky_d;
`endif
          end
        end

        ST_DONE: begin
          // Single dead cycle: edges detected here are dropped
          gate_q     <= '0;
          edge_cnt_q <= '0;
          state_q    <= Enable ? ST_MEASURE : ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Result = result_q;
  assign Valid  = valid_q;

  generate
    if (W >= 9) begin : g_led_wide
      assign res_led = Result[8:0];
    end else begin : g_led_narrow
      assign res_led = {{(9 - W){1'b0}}, Result};
    end
  endgenerate

  assign LEDR = {Ovf, res_led};

endmodule
